memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
- Shares the single-port SoC memory between two bus masters: master 0 = CPU core data/fetch port, master 1 = UART boot loader / debug writer.
- Sits between the masters and the memory block.
- Grants one transaction at a time, either round-robin or fixed priority.
- Guards each transaction with a timeout counter so that a non-responding slave cannot hang the bus.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width on all ports.
- PRIORITY_MODE, 0, selects arbitration: 0 = round-robin; 1 = fixed priority, master 0 wins.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ack before an error ack is issued. Legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_rd, m0_wr  in  1 each  master 0 read/write request, level, held until ack.
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data.
- m0_ack  out  1  master 0 completion pulse.
- m0_err  out  1  master 0 timeout flag, valid with ack.
- m1_rd, m1_wr, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same as master 0, for master 1.
- mem_rd, mem_wr  out  1 each  memory request.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_ack  in  1  memory completion, at least 1 cycle after request.
- grant  out  2  one-hot current owner, 00 when idle.
- busy  out  1  high in BUSY state.

Behaviour:
- **State machine:** two states, IDLE and BUSY. Registers: state, owner (1b), last_grant (1b), is_write (1b), timeout counter (16b).
- **Reset (reset=0), asynchronous, any time including mid-transaction:**
  - state=IDLE, owner=0, last_grant=1, counter=0.
  - All outputs 0: mem_rd, mem_wr, mem_addr, mem_wdata, grant, busy, all acks, errs and rdata.
  - An in-flight memory access is abandoned and no ack is issued.
- **IDLE:**
  - A request from master X is (mX_rd | mX_wr).
  - With no request, remain in IDLE; mem_* outputs are 0.
  - Round-robin mode: if both masters request, the master != last_grant wins. A single requester always wins.
  - Fixed priority mode: master 0 wins whenever it requests.
  - On a win: owner := winner; is_write := winner_wr (wr takes precedence if rd and wr are both high); counter := 0; next state BUSY.
  - IDLE always lasts at least 1 cycle between transactions, so arbitration latency is 1 cycle.
- **BUSY:**
  - mem_addr and mem_wdata are muxed combinationally from the owner's live inputs.
  - mem_wr = is_write, mem_rd = !is_write.
  - grant = one-hot(owner), busy = 1.
  - Masters must keep request, address and data stable until ack. A request dropped mid-BUSY is ignored; the transaction completes anyway.
  - counter increments every BUSY cycle.
- **Normal completion (mem_ack=1 in BUSY):**
  - mOwner_ack = 1 for exactly that cycle, combinationally.
  - mOwner_rdata = mem_rdata (undefined for writes; driven as mem_rdata).
  - mOwner_err = 0.
  - The non-owner's ack, err and rdata stay 0.
  - Next state IDLE; last_grant := owner.
- **Timeout (counter == TIMEOUT_CYCLES-1 with mem_ack=0):**
  - mOwner_ack = 1, mOwner_err = 1, mOwner_rdata = 0.
  - mem_rd and mem_wr deassert next cycle; next state IDLE; last_grant := owner.
  - A mem_ack arriving while in IDLE is ignored.
- **Masters after ack:**
  - A master keeping its request high after ack is treated as a new request in IDLE.
  - In round-robin mode the other master wins if it is also requesting, which gives starvation freedom.
- **Throughput:** best case one transaction per 3 cycles (IDLE, BUSY, mem_ack in the next BUSY cycle).
- **Widths:** the counter saturates at TIMEOUT_CYCLES; there is no wrap.

Decomposition:
- Shared package/header constants:
  - State encodings ST_IDLE=1'b0, ST_BUSY=1'b1.
  - MASTER_CPU=0, MASTER_UART=1.
  - PRIO_RR=0, PRIO_FIXED=0/1 mode values.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: `rr_arbiter_2`. It is purely combinational: inputs req[1:0], last_grant and mode; output winner plus a valid flag.
- FSM, counter and datapath mux stay in the top module.

Test Plan:
1. **Reset values:** reset=0 for 3 cycles with m0_rd=1 → all outputs 0, grant=00. Release reset → m0 granted 1 cycle later (grant=01, mem_rd=1, mem_addr=m0_addr).
2. **Single read:** m0_rd, addr 0x0000_0010; memory returns mem_ack with 0xCAFEBABE 2 cycles after mem_rd → m0_ack=1 for exactly one cycle, m0_rdata=0xCAFEBABE, m0_err=0, m1_ack=0.
3. **Round-robin tie:** m0_wr (addr 0x20, data 0x11) and m1_wr (addr 0x24, data 0x22) held together, memory acks in 1 cycle.
   - Expected grant sequence 01, 10, 01, 10.
   - Memory receives (0x20, 0x11) then (0x24, 0x22), alternating.
   - Repeat with PRIORITY_MODE=1 → grant stays 01 while m0 requests.
4. **Timeout:** TIMEOUT_CYCLES=4, m1_rd, mem_ack tied 0 → m1_ack=1, m1_err=1, m1_rdata=0 on the 4th BUSY cycle. Arbiter then returns to IDLE, and a late mem_ack is ignored.
5. **Reset mid-transaction:** assert reset in the 2nd BUSY cycle → mem_rd/mem_wr drop asynchronously (same cycle) and no ack is issued. After release, m0 wins a tie first.
6. **rd+wr together:** m0_rd=m0_wr=1 → mem_wr=1, mem_rd=0. The transaction completes as a write.

Source files
------------

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared constants and types for the two-master memory bus arbiter.
package memory_bus_arbiter_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Master identifiers (also the value held in the owner register)
  localparam logic MASTER_CPU  = 1'b0;
  localparam logic MASTER_UART = 1'b1;

  // Arbitration mode values for PRIORITY_MODE
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Default transaction timeout and the width of its counter
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int CNT_WIDTH              = 16;

  // Internal state made visible for checkers and debug
  typedef struct packed {
    logic [0:0]           state;
    logic                 owner;
    logic                 last_grant;
    logic                 is_write;
    logic [CNT_WIDTH-1:0] count;
  } arb_dbg_t;

  // One-hot grant vector for a given owner
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr.sv
// Combinational two-way arbiter: picks a winner among the current requesters,
// either alternating against the last grant or with master 0 as fixed winner.
module rr_arbiter_2
  import memory_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mode,        // 0 = round-robin, 1 = fixed priority (master 0 wins)
  output logic       winner,
  output logic       valid
);

  // Winner selection; a lone requester always wins, ties use mode
  always_comb begin
    valid  = |req;
    winner = MASTER_CPU;
    if (req == 2'b11) begin
      winner = mode ? MASTER_CPU : ~last_grant;
    end else if (req == 2'b10) begin
      winner = MASTER_UART;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one single-port memory between the CPU (master 0) and the UART boot
// loader (master 1). One transaction at a time, guarded by a timeout so a
// silent slave cannot hang the bus.
//
// Handshake: a master raises rd and/or wr (level) with address/data and holds
// them stable until it sees its ack pulse; the ack cycle is the only completion
// indication and err qualifies it (timeout). Towards memory, mem_rd/mem_wr stay
// high for the whole BUSY phase until mem_ack is seen or the timeout fires;
// mem_ack is only honoured in BUSY.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = PRIO_RR,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES   // legal 1..65535
)(
  input  logic                  clk,
  input  logic                  reset,      // asynchronous, active low

  input  logic                  m0_rd,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,

  input  logic                  m1_rd,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,

  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,

  output logic [1:0]            grant,
  output logic                  busy,
  output arb_dbg_t              dbg
);

  // Counter compare points: fire on the last allowed BUSY cycle, never wrap
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_SAT  = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [0:0]           state;
  logic                 owner;
  logic                 last_grant;
  logic                 is_write;
  logic [CNT_WIDTH-1:0] tmo_cnt;

  logic [1:0] req;
  logic       win;
  logic       win_valid;
  logic       win_wr;
  logic       in_busy;
  logic       done_ok;
  logic       timeout;
  logic       done;

  assign req = {m1_rd | m1_wr, m0_rd | m0_wr};

  rr_arbiter_2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .mode       (PRIORITY_MODE == PRIO_FIXED),
    .winner     (win),
    .valid      (win_valid)
  );

  // A write request takes precedence when rd and wr are both raised
  assign win_wr  = win ? m1_wr : m0_wr;

  assign in_busy = (state == ST_BUSY);
  assign done_ok = in_busy && mem_ack;
  assign timeout = in_busy && !mem_ack && (tmo_cnt == TMO_LAST);
  assign done    = done_ok || timeout;

  // FSM, owner bookkeeping and the per-transaction timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= MASTER_CPU;
      last_grant <= MASTER_UART;
      is_write   <= 1'b0;
      tmo_cnt    <= '0;
    end else if (state == ST_IDLE) begin
      if (win_valid) begin
        state    <= ST_BUSY;
        owner    <= win;
        is_write <= win_wr;
        tmo_cnt  <= '0;
      end
    end else begin
      if (tmo_cnt != TMO_SAT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (done) begin
        state      <= ST_IDLE;
        last_grant <= owner;
      end
    end
  end

  // Memory-side mux and master-side completion, all quiet outside BUSY
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    grant     = 2'b00;
    busy      = 1'b0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = '0;
    if (in_busy) begin
      mem_wr    = is_write;
      mem_rd    = !is_write;
      mem_addr  = owner ? m1_addr  : m0_addr;
      mem_wdata = owner ? m1_wdata : m0_wdata;
      grant     = owner_onehot(owner);
      busy      = 1'b1;
      if (owner == MASTER_CPU) begin
        m0_ack   = done;
        m0_err   = timeout;
        m0_rdata = done_ok ? mem_rdata : '0;
      end else begin
        m1_ack   = done;
        m1_err   = timeout;
        m1_rdata = done_ok ? mem_rdata : '0;
      end
    end
  end

  // Debug view of the internal registers
  assign dbg = '{state: state, owner: owner, last_grant: last_grant,
                 is_write: is_write, count: tmo_cnt};

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: instance 0 round-robin (timeout 4),
// instance 1 fixed priority (timeout 6). Directed steps plus a randomized
// transaction-level run checked against a reference model.
module tb_memory_bus_arbiter;
  import memory_bus_arbiter_pkg::*;

  int total = 0;
  int bad   = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn [2];

  // per-instance, per-master signals: [inst][master]
  logic        mrd    [2][2];
  logic        mwr    [2][2];
  logic [31:0] maddr  [2][2];
  logic [31:0] mwdata [2][2];
  logic [31:0] mrdata [2][2];
  logic        mack   [2][2];
  logic        merr   [2][2];

  logic        mem_rd_o    [2];
  logic        mem_wr_o    [2];
  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic [31:0] mem_rdata_i [2];
  logic        mem_ack_i   [2];
  logic [1:0]  grant_o     [2];
  logic        busy_o      [2];
  arb_dbg_t    dbg_o       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    memory_bus_arbiter #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .PRIORITY_MODE  (g),
      .TIMEOUT_CYCLES ((g == 0) ? 4 : 6)
    ) u_dut (
      .clk       (clk),
      .reset     (rstn[g]),
      .m0_rd     (mrd[g][0]),
      .m0_wr     (mwr[g][0]),
      .m0_addr   (maddr[g][0]),
      .m0_wdata  (mwdata[g][0]),
      .m0_rdata  (mrdata[g][0]),
      .m0_ack    (mack[g][0]),
      .m0_err    (merr[g][0]),
      .m1_rd     (mrd[g][1]),
      .m1_wr     (mwr[g][1]),
      .m1_addr   (maddr[g][1]),
      .m1_wdata  (mwdata[g][1]),
      .m1_rdata  (mrdata[g][1]),
      .m1_ack    (mack[g][1]),
      .m1_err    (merr[g][1]),
      .mem_rd    (mem_rd_o[g]),
      .mem_wr    (mem_wr_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (mem_rdata_i[g]),
      .mem_ack   (mem_ack_i[g]),
      .grant     (grant_o[g]),
      .busy      (busy_o[g]),
      .dbg       (dbg_o[g])
    );
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input int k);
    for (int m = 0; m < 2; m++) begin
      mrd[k][m]    = 1'b0;
      mwr[k][m]    = 1'b0;
      maddr[k][m]  = '0;
      mwdata[k][m] = '0;
    end
    mem_ack_i[k]   = 1'b0;
    mem_rdata_i[k] = '0;
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    string t;
    t = $sformatf("%s_k%0d", tag, k);
    chk({t, "_grant"},  32'(grant_o[k]),  32'h0);
    chk({t, "_busy"},   32'(busy_o[k]),   32'h0);
    chk({t, "_state"},  32'(dbg_o[k].state), 32'(ST_IDLE));
    chk({t, "_memrd"},  32'(mem_rd_o[k]), 32'h0);
    chk({t, "_memwr"},  32'(mem_wr_o[k]), 32'h0);
    chk({t, "_maddr"},  mem_addr_o[k],    32'h0);
    chk({t, "_mwdata"}, mem_wdata_o[k],   32'h0);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_ack%0d", t, m),   32'(mack[k][m]), 32'h0);
      chk($sformatf("%s_err%0d", t, m),   32'(merr[k][m]), 32'h0);
      chk($sformatf("%s_rdata%0d", t, m), mrdata[k][m],    32'h0);
    end
  endtask

  task automatic chk_busy(input int k, input string tag, input int own, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic ack, input logic err, input logic [31:0] rdata);
    string t;
    int    oth;
    t   = $sformatf("%s_k%0d", tag, k);
    oth = 1 - own;
    chk({t, "_grant"},  32'(grant_o[k]),  (own == 1) ? 32'h2 : 32'h1);
    chk({t, "_busy"},   32'(busy_o[k]),   32'h1);
    chk({t, "_state"},  32'(dbg_o[k].state), 32'(ST_BUSY));
    chk({t, "_memwr"},  32'(mem_wr_o[k]), 32'(wr));
    chk({t, "_memrd"},  32'(mem_rd_o[k]), 32'(!wr));
    chk({t, "_maddr"},  mem_addr_o[k],    addr);
    chk({t, "_mwdata"}, mem_wdata_o[k],   wdata);
    chk({t, "_ack"},    32'(mack[k][own]), 32'(ack));
    chk({t, "_err"},    32'(merr[k][own]), 32'(err));
    chk({t, "_rdata"},  mrdata[k][own],    rdata);
    chk({t, "_oack"},   32'(mack[k][oth]), 32'h0);
    chk({t, "_oerr"},   32'(merr[k][oth]), 32'h0);
    chk({t, "_ordata"}, mrdata[k][oth],    32'h0);
  endtask

  // Reset pulse; ends one step into an IDLE cycle with reset released
  task automatic rst_pulse(input int k);
    clear_inputs(k);
    rstn[k] = 1'b0;
    #1;
    chk_idle(k, "rst_pulse");
    tick();
    tick();
    rstn[k] = 1'b1;
  endtask

  // Tied writes from both masters, memory acks on the first BUSY cycle
  task automatic tie_test(input int k);
    int own;
    rst_pulse(k);
    mwr[k][0] = 1'b1; maddr[k][0] = 32'h20; mwdata[k][0] = 32'h11;
    mwr[k][1] = 1'b1; maddr[k][1] = 32'h24; mwdata[k][1] = 32'h22;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i[k] = 1'b0;
      #1;
      chk_idle(k, "tie_idle");
      tick();
      mem_ack_i[k]   = 1'b1;
      mem_rdata_i[k] = 32'h5A5A_0000 + 32'(i);
      #1;
      own = (k == 0) ? (i % 2) : 0;   // alternate in RR, master 0 always in fixed
      chk_busy(k, $sformatf("tie%0d", i), own, 1'b1,
               (own == 1) ? 32'h24 : 32'h20, (own == 1) ? 32'h22 : 32'h11,
               1'b1, 1'b0, 32'h5A5A_0000 + 32'(i));
      tick();
    end
    clear_inputs(k);
  endtask

  // Randomized transactions against a transaction-level model
  task automatic run_random(input int k, input int n);
    logic        pend   [2];
    logic        p_rd   [2];
    logic        p_wr   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    int          last_g, win, d, tmo, kind;
    logic        w_wr, fin_ok, fin_to;
    logic [31:0] rv;
    tmo = (k == 0) ? 4 : 6;
    rst_pulse(k);
    last_g = 1;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_rd[m] = 1'b0; p_wr[m] = 1'b0; p_addr[m] = '0; p_data[m] = '0;
    end
    for (int it = 0; it < n; it++) begin
      // IDLE cycle: new requests from masters without a pending one
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 3) != 0)) begin
          kind      = int'($urandom_range(0, 2));   // 0 rd, 1 wr, 2 rd+wr
          pend[m]   = 1'b1;
          p_rd[m]   = (kind != 1);
          p_wr[m]   = (kind != 0);
          p_addr[m] = $urandom;
          p_data[m] = $urandom;
        end
        mrd[k][m]    = pend[m] && p_rd[m];
        mwr[k][m]    = pend[m] && p_wr[m];
        maddr[k][m]  = pend[m] ? p_addr[m] : 32'h0;
        mwdata[k][m] = pend[m] ? p_data[m] : 32'h0;
      end
      mem_ack_i[k]   = 1'($urandom_range(0, 1));   // stray ack while idle must be ignored
      mem_rdata_i[k] = $urandom;
      #1;
      chk_idle(k, "rnd_idle");
      tick();
      if (!pend[0] && !pend[1]) continue;

      if (pend[0] && pend[1]) win = (k == 1) ? 0 : (1 - last_g);
      else                    win = pend[0] ? 0 : 1;
      w_wr = p_wr[win];
      d    = int'($urandom_range(1, tmo));   // ack arrives on BUSY cycle 1+d
      for (int i = 1; i <= tmo; i++) begin
        if (i >= 2 && $urandom_range(0, 3) == 0) begin
          mrd[k][win] = 1'b0;                // dropped request must not matter
          mwr[k][win] = 1'b0;
        end
        fin_ok = (i == 1 + d);
        fin_to = !fin_ok && (i == tmo);
        rv     = $urandom;
        mem_ack_i[k]   = fin_ok;
        mem_rdata_i[k] = rv;
        #1;
        chk_busy(k, "rnd", win, w_wr, p_addr[win], p_data[win],
                 fin_ok || fin_to, fin_to, fin_ok ? rv : 32'h0);
        tick();
        if (fin_ok || fin_to) break;
      end
      pend[win] = 1'b0;
      last_g    = win;
    end
    clear_inputs(k);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0;
      clear_inputs(k);
    end

    // Reset held with a pending read: everything stays quiet
    mrd[0][0]   = 1'b1;
    maddr[0][0] = 32'h0000_0010;
    repeat (3) begin
      tick();
      #1;
      chk_idle(0, "rst_hold");
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    // First cycle after release is IDLE, then m0 granted; read returns on BUSY cycle 3
    tick();
    #1;
    chk_busy(0, "rd_b1", 0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    #1;
    chk_busy(0, "rd_b2", 0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    mem_ack_i[0]   = 1'b1;
    mem_rdata_i[0] = 32'hCAFE_BABE;
    #1;
    chk_busy(0, "rd_b3", 0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hCAFE_BABE);
    tick();
    mrd[0][0]    = 1'b0;
    mem_ack_i[0] = 1'b0;
    #1;
    chk_idle(0, "rd_after");
    tick();

    // Tied writers: round-robin alternates, fixed priority keeps master 0
    tie_test(0);
    tie_test(1);

    // Timeout on master 1, then a late ack in IDLE is ignored
    rst_pulse(0);
    mrd[0][1]   = 1'b1;
    maddr[0][1] = 32'h40;
    #1;
    chk_idle(0, "tmo_idle");
    tick();
    for (int i = 1; i <= 4; i++) begin
      mem_ack_i[0]   = 1'b0;
      mem_rdata_i[0] = 32'hFFFF_FFFF;
      #1;
      chk_busy(0, $sformatf("tmo_b%0d", i), 1, 1'b0, 32'h40, 32'h0,
               (i == 4), (i == 4), 32'h0);
      tick();
    end
    mrd[0][1]    = 1'b0;
    mem_ack_i[0] = 1'b1;
    #1;
    chk_idle(0, "tmo_late_ack");
    tick();
    mem_ack_i[0] = 1'b0;
    #1;
    chk_idle(0, "tmo_after");
    tick();

    // rd+wr together completes as a write
    mrd[0][0] = 1'b1; mwr[0][0] = 1'b1; maddr[0][0] = 32'h80; mwdata[0][0] = 32'h88;
    #1;
    chk_idle(0, "rdwr_idle");
    tick();
    mem_ack_i[0]   = 1'b1;
    mem_rdata_i[0] = 32'h0BAD_F00D;
    #1;
    chk_busy(0, "rdwr", 0, 1'b1, 32'h80, 32'h88, 1'b1, 1'b0, 32'h0BAD_F00D);
    tick();
    clear_inputs(0);

    // Reset mid-transaction: m0 completes (last grant m0), m1 write cut by reset
    rst_pulse(0);
    mrd[0][0] = 1'b1; maddr[0][0] = 32'h50;
    #1;
    chk_idle(0, "rmid_idle0");
    tick();
    mem_ack_i[0]   = 1'b1;
    mem_rdata_i[0] = 32'h1234_5678;
    #1;
    chk_busy(0, "rmid_m0", 0, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    tick();
    mrd[0][0]    = 1'b0;
    mem_ack_i[0] = 1'b0;
    mwr[0][1] = 1'b1; maddr[0][1] = 32'h60; mwdata[0][1] = 32'h66;
    #1;
    chk_idle(0, "rmid_idle1");
    tick();
    #1;
    chk_busy(0, "rmid_b1", 1, 1'b1, 32'h60, 32'h66, 1'b0, 1'b0, 32'h0);
    tick();
    #1;
    chk_busy(0, "rmid_b2", 1, 1'b1, 32'h60, 32'h66, 1'b0, 1'b0, 32'h0);
    rstn[0]      = 1'b0;
    mem_ack_i[0] = 1'b1;
    #1;
    chk_idle(0, "rmid_async");
    tick();
    rstn[0]      = 1'b1;
    mem_ack_i[0] = 1'b0;
    mrd[0][0] = 1'b1; maddr[0][0] = 32'h70;
    #1;
    chk_idle(0, "rmid_release");
    tick();
    mem_ack_i[0]   = 1'b1;
    mem_rdata_i[0] = 32'h7777_0000;
    #1;
    chk_busy(0, "rmid_tie", 0, 1'b0, 32'h70, 32'h0, 1'b1, 1'b0, 32'h7777_0000);
    tick();
    clear_inputs(0);

    // Randomized traffic on both arbitration modes
    run_random(0, 200);
    run_random(1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
